// File: rtl/alp_pkg.sv
// Shared definitions for the alp 4-bit arithmetic/logic processor:
// one-hot state encodings, opcode constants and datapath widths.
package alp_pkg;
  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  typedef enum logic [4:0] {
    ST_EMPTY = 5'b00001,
    ST_ONE   = 5'b00010,
    ST_FULL  = 5'b00100,
    ST_EXEC  = 5'b01000,
    ST_ERROR = 5'b10000
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;
endpackage

// File: rtl/alp_alu.sv
// Combinational ALU for alp: mod-16 result plus overflow (ADD carry / SUB borrow).
module alp_alu
  import alp_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] res_o,
  output logic              ovf_o
);
  logic [DATA_W:0] sum;

  assign sum = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    res_o = '0;
    ovf_o = 1'b0;
    case (op_i)
      OP_ADD: begin res_o = sum[DATA_W-1:0]; ovf_o = sum[DATA_W]; end
      OP_SUB: begin res_o = a_i - b_i;       ovf_o = (a_i < b_i); end
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      OP_NOT: res_o = ~a_i;
      OP_SHL: res_o = {a_i[DATA_W-2:0], 1'b0};
      OP_SHR: res_o = {1'b0, a_i[DATA_W-1:1]};
      default: res_o = '0;
    endcase
  end
endmodule

// File: rtl/alp.sv
// alp top: serial operand load, compute/writeback FSM and sticky error state.
// Define ALP_DEBUG_STATE_EN to expose current (CS) and next (NS) state ports.
module alp
  import alp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_DATA_IN,
  input  logic [OP_W-1:0]   i_OP,
  input  logic              i_COMP,
  input  logic              i_LOAD,
  input  logic              i_CLR,
  output logic              ERR,
  output logic [DATA_W-1:0] o_R0,
  output logic [DATA_W-1:0] o_R1
`ifdef ALP_DEBUG_STATE_EN
  ,
  output logic [4:0]        CS,
  output logic [4:0]        NS
`endif
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] r0_q, r0_d, r1_q, r1_d, res_q, res_d;
  logic              ovf_q, ovf_d, err_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  alp_alu u_alu (
    .a_i  (r0_q),
    .b_i  (r1_q),
    .op_i (i_OP),
    .res_o(alu_res),
    .ovf_o(alu_ovf)
  );

  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    if (i_CLR) begin
      state_d = ST_EMPTY;
      r0_d    = '0;
      r1_d    = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (i_COMP)      state_d = ST_ERROR;
          else if (i_LOAD) begin r0_d = i_DATA_IN; state_d = ST_ONE; end
        end
        ST_ONE: begin
          if (i_COMP)      state_d = ST_ERROR;
          else if (i_LOAD) begin r1_d = i_DATA_IN; state_d = ST_FULL; end
        end
        ST_FULL: begin
          if (i_COMP) begin
            res_d   = alu_res;
            ovf_d   = alu_ovf;
            state_d = ST_EXEC;
          end else if (i_LOAD) begin
            state_d = ST_ERROR;
          end
        end
        // Writeback cycle: the wrapped result lands even when it overflowed.
        ST_EXEC: begin
          r0_d    = res_q;
          state_d = ovf_q ? ST_ERROR : ST_FULL;
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      r0_q    <= '0;
      r1_q    <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      err_q   <= (state_d == ST_ERROR);
    end
  end

  assign ERR  = err_q;
  assign o_R0 = r0_q;
  assign o_R1 = r1_q;

`ifdef ALP_DEBUG_STATE_EN
  assign CS = state_q;
  assign NS = state_d;
`endif
endmodule

// File: tb/tb_alp.sv
// Directed scoreboard bench for alp: each step queues its expected registers/ERR
// and the entry is popped and compared one clock later.
module tb_alp;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] i_DATA_IN = '0;
  logic [2:0] i_OP = '0;
  logic       i_COMP = 1'b0, i_LOAD = 1'b0, i_CLR = 1'b0;
  logic       ERR;
  logic [3:0] o_R0, o_R1;
`ifdef ALP_DEBUG_STATE_EN
  logic [4:0] CS, NS;
`endif

  alp dut (
    .clk(clk), .reset(reset), .i_DATA_IN(i_DATA_IN), .i_OP(i_OP),
    .i_COMP(i_COMP), .i_LOAD(i_LOAD), .i_CLR(i_CLR),
    .ERR(ERR), .o_R0(o_R0), .o_R1(o_R1)
`ifdef ALP_DEBUG_STATE_EN
    , .CS(CS), .NS(NS)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r0;
    logic [3:0] r1;
    logic       err;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic cmp(input string tag, input string fld, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s got %h exp %h", tag, fld, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge state, then check it.
  task automatic step(input string tag, input logic rst, input logic clr, input logic comp,
                      input logic load, input logic [2:0] op, input logic [3:0] d,
                      input logic [3:0] er0, input logic [3:0] er1, input logic eerr);
    exp_t e;
    reset = rst; i_CLR = clr; i_COMP = comp; i_LOAD = load; i_OP = op; i_DATA_IN = d;
    e.r0 = er0; e.r1 = er1; e.err = eerr; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0; i_CLR = 1'b0; i_COMP = 1'b0; i_LOAD = 1'b0;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s scoreboard empty got 0 exp 1", tag);
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "R0", {1'b0, o_R0}, {1'b0, e.r0});
      cmp(e.tag, "R1", {1'b0, o_R1}, {1'b0, e.r1});
      cmp(e.tag, "ERR", {4'b0, ERR}, {4'b0, e.err});
    end
  endtask

  //                    tag         rst clr cmp ld  op      d      r0    r1    err
  initial begin
    step("reset",       1, 0, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
    // Load, third-operand error, clear
    step("ld6",         0, 0, 0, 1, 3'd0, 4'h6, 4'h6, 4'h0, 0);
    step("ld9",         0, 0, 0, 1, 3'd0, 4'h9, 4'h6, 4'h9, 0);
    step("ld3rd",       0, 0, 0, 1, 3'd0, 4'h4, 4'h6, 4'h9, 1);
    step("clr",         0, 1, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
    // ADD held two cycles, then AND on the updated R0
    step("ld6b",        0, 0, 0, 1, 3'd0, 4'h6, 4'h6, 4'h0, 0);
    step("ld9b",        0, 0, 0, 1, 3'd0, 4'h9, 4'h6, 4'h9, 0);
    step("add_exec",    0, 0, 1, 0, 3'd0, 4'h0, 4'h6, 4'h9, 0);
    step("add_wb",      0, 0, 1, 0, 3'd0, 4'h0, 4'hF, 4'h9, 0);
    step("and_exec",    0, 0, 1, 0, 3'd2, 4'h0, 4'hF, 4'h9, 0);
    step("and_wb",      0, 0, 0, 0, 3'd0, 4'h0, 4'h9, 4'h9, 0);
    step("clr2",        0, 1, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
    // SUB borrow -> ERROR, wrapped result kept, ERROR ignores LOAD/COMP
    step("ld3",         0, 0, 0, 1, 3'd0, 4'h3, 4'h3, 4'h0, 0);
    step("ld9c",        0, 0, 0, 1, 3'd0, 4'h9, 4'h3, 4'h9, 0);
    step("sub_exec",    0, 0, 1, 0, 3'd1, 4'h0, 4'h3, 4'h9, 0);
    step("sub_wb",      0, 0, 0, 0, 3'd0, 4'h0, 4'hA, 4'h9, 1);
    step("err_ld",      0, 0, 0, 1, 3'd0, 4'h1, 4'hA, 4'h9, 1);
    step("err_comp",    0, 0, 1, 0, 3'd0, 4'h0, 4'hA, 4'h9, 1);
    step("clr3",        0, 1, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
    // NOT / SHL / SHR chain
    step("ld3d",        0, 0, 0, 1, 3'd0, 4'h3, 4'h3, 4'h0, 0);
    step("ldE",         0, 0, 0, 1, 3'd0, 4'hE, 4'h3, 4'hE, 0);
    step("not_exec",    0, 0, 1, 0, 3'd5, 4'h0, 4'h3, 4'hE, 0);
    step("not_wb",      0, 0, 0, 0, 3'd0, 4'h0, 4'hC, 4'hE, 0);
    step("shl_exec",    0, 0, 1, 0, 3'd6, 4'h0, 4'hC, 4'hE, 0);
    step("shl_wb",      0, 0, 0, 0, 3'd0, 4'h0, 4'h8, 4'hE, 0);
    step("shr_exec",    0, 0, 1, 0, 3'd7, 4'h0, 4'h8, 4'hE, 0);
    step("shr_wb",      0, 0, 0, 0, 3'd0, 4'h0, 4'h4, 4'hE, 0);
    step("clr4",        0, 1, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
    // COMP in EMPTY and in ONE
    step("comp_empty",  0, 0, 1, 0, 3'd0, 4'h0, 4'h0, 4'h0, 1);
    step("clr5",        0, 1, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
    step("ld5",         0, 0, 0, 1, 3'd0, 4'h5, 4'h5, 4'h0, 0);
    step("comp_one",    0, 0, 1, 0, 3'd0, 4'h0, 4'h5, 4'h0, 1);
    step("clr6",        0, 1, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
    // CLR beats COMP/LOAD
    step("ld6e",        0, 0, 0, 1, 3'd0, 4'h6, 4'h6, 4'h0, 0);
    step("ld9e",        0, 0, 0, 1, 3'd0, 4'h9, 4'h6, 4'h9, 0);
    step("clr_cmp_ld",  0, 1, 1, 1, 3'd0, 4'h7, 4'h0, 4'h0, 0);
    step("clr_ld",      0, 1, 0, 1, 3'd0, 4'h7, 4'h0, 4'h0, 0);
    step("ld2",         0, 0, 0, 1, 3'd0, 4'h2, 4'h2, 4'h0, 0);
    // Reset during EXEC suppresses the writeback
    step("ld3f",        0, 0, 0, 1, 3'd0, 4'h3, 4'h2, 4'h3, 0);
    step("add_exec2",   0, 0, 1, 0, 3'd0, 4'h0, 4'h2, 4'h3, 0);
    step("rst_exec",    1, 0, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
    step("post_rst",    0, 0, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
    step("ld1_empty",   0, 0, 0, 1, 3'd0, 4'h1, 4'h1, 4'h0, 0);
    step("clr7",        0, 1, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
    // ADD carry-out -> ERROR with wrapped result
    step("ld9g",        0, 0, 0, 1, 3'd0, 4'h9, 4'h9, 4'h0, 0);
    step("ld8g",        0, 0, 0, 1, 3'd0, 4'h8, 4'h9, 4'h8, 0);
    step("addc_exec",   0, 0, 1, 0, 3'd0, 4'h0, 4'h9, 4'h8, 0);
    step("addc_wb",     0, 0, 0, 0, 3'd0, 4'h0, 4'h1, 4'h8, 1);
    step("clr8",        0, 1, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
    // COMP held high re-executes every two cycles; then XOR and OR
    step("ld1a",        0, 0, 0, 1, 3'd0, 4'h1, 4'h1, 4'h0, 0);
    step("ld1b",        0, 0, 0, 1, 3'd0, 4'h1, 4'h1, 4'h1, 0);
    step("hold_e1",     0, 0, 1, 0, 3'd0, 4'h0, 4'h1, 4'h1, 0);
    step("hold_w1",     0, 0, 1, 0, 3'd0, 4'h0, 4'h2, 4'h1, 0);
    step("hold_e2",     0, 0, 1, 0, 3'd0, 4'h0, 4'h2, 4'h1, 0);
    step("hold_w2",     0, 0, 1, 0, 3'd0, 4'h0, 4'h3, 4'h1, 0);
    step("xor_exec",    0, 0, 1, 0, 3'd4, 4'h0, 4'h3, 4'h1, 0);
    step("xor_wb",      0, 0, 0, 0, 3'd0, 4'h0, 4'h2, 4'h1, 0);
    step("or_exec",     0, 0, 1, 0, 3'd3, 4'h0, 4'h2, 4'h1, 0);
    step("or_wb",       0, 0, 0, 0, 3'd0, 4'h0, 4'h3, 4'h1, 0);
    step("sub_ok_exec", 0, 0, 1, 0, 3'd1, 4'h0, 4'h3, 4'h1, 0);
    step("sub_ok_wb",   0, 0, 0, 0, 3'd0, 4'h0, 4'h2, 4'h1, 0);
`ifdef ALP_DEBUG_STATE_EN
    // Debug state trace across load, load, compute, writeback
    step("dbg_clr",     0, 1, 0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 0);
    cmp("dbg_clr", "CS", CS, 5'b00001);
    step("dbg_ld1",     0, 0, 0, 1, 3'd0, 4'h4, 4'h4, 4'h0, 0);
    cmp("dbg_ld1", "CS", CS, 5'b00010);
    step("dbg_ld2",     0, 0, 0, 1, 3'd0, 4'h2, 4'h4, 4'h2, 0);
    cmp("dbg_ld2", "CS", CS, 5'b00100);
    step("dbg_exec",    0, 0, 1, 0, 3'd0, 4'h0, 4'h4, 4'h2, 0);
    cmp("dbg_exec", "CS", CS, 5'b01000);
    cmp("dbg_exec", "NS", NS, 5'b00100);
    step("dbg_wb",      0, 0, 0, 0, 3'd0, 4'h0, 4'h6, 4'h2, 0);
    cmp("dbg_wb", "CS", CS, 5'b00100);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alp.md
Name: alp

Overview:
- 4-bit two-operand arithmetic/logic processor.
- Operands are loaded serially from one 4-bit input into registers R0 and R1.
- A compute command applies a 3-bit opcode and writes the result back to R0.
- A sticky error state flags misuse or arithmetic overflow until cleared.
- Leaf datapath/control block, driven directly by user-level strobes.

Parameters:
- None. Data width is fixed at 4 bits; opcode width is fixed at 3 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- i_DATA_IN  input  4  operand data for LOAD
- i_OP  input  3  opcode, sampled with i_COMP
- i_COMP  input  1  compute strobe
- i_LOAD  input  1  load strobe
- i_CLR  input  1  synchronous clear command
- ERR  output  1  error flag, high while in ERROR state
- o_R0  output  4  register R0 (first operand / result)
- o_R1  output  4  register R1 (second operand)

Behaviour:
- Reset (synchronous, active-high, highest priority): R0=0, R1=0, state=EMPTY, ERR=0.
- Command priority each cycle: reset > i_CLR > i_COMP > i_LOAD.
- i_CLR in any state: R0=0, R1=0, state goes to EMPTY, ERR drops next cycle.
- States, one-hot 5-bit encoding:
  - EMPTY=00001
  - ONE=00010
  - FULL=00100
  - EXEC=01000
  - ERROR=10000
- EMPTY:
  - LOAD: R0<=i_DATA_IN, go to ONE.
  - COMP: go to ERROR.
- ONE:
  - LOAD: R1<=i_DATA_IN, go to FULL.
  - COMP: go to ERROR.
- FULL:
  - COMP: capture i_OP and compute the result from R0,R1 into an internal result register, go to EXEC.
  - LOAD: go to ERROR (third operand); registers unchanged.
- EXEC:
  - All inputs except reset and CLR are ignored.
  - R0<=result.
  - Go to FULL, or to ERROR if the operation overflowed.
  - Latency from the COMP edge to the R0 update is 2 clocks.
- ERROR: ERR=1; R0/R1 hold; LOAD and COMP ignored; only CLR or reset exits.
- ERR is a registered output, equal to (state==ERROR).
- Operations, all mod 16:
  - 000 ADD: R0+R1; overflow if carry-out.
  - 001 SUB: R0-R1; overflow if R0<R1 (borrow).
  - 010 AND: R0&R1.
  - 011 OR: R0|R1.
  - 100 XOR: R0^R1.
  - 101 NOT: ~R0.
  - 110 SHL: R0<<1, zero fill.
  - 111 SHR: R0>>1, zero fill.
- On overflow, the wrapped result is still written to R0.
- R1 is never modified by compute.
- Chained ops: after EXEC returns to FULL, a new COMP uses the updated R0.
- A COMP held high continuously re-executes every 2 cycles.

Optional Feature:
- Macro ALP_DEBUG_STATE_EN.
- When defined: adds outputs CS[4:0] (current state) and NS[4:0] (combinational next state), using the one-hot encoding above.
- When undefined: these ports do not exist; function is otherwise identical.

Decomposition:
- Shared package alp_pkg holds:
  - state encodings (EMPTY..ERROR)
  - opcode constants (OP_ADD..OP_SHR)
  - DATA_W=4 and OP_W=3 localparams
- One sub-module, alp_alu: purely combinational (a, b, op) -> (result[3:0], ovf).
- FSM and registers stay in alp.

Test Plan:
- Reset, then LOAD 6, then LOAD 9 -> R0=6, R1=9, ERR=0; a further LOAD 4 -> ERR=1, R0=6, R1=9; then CLR -> R0=0, R1=0, ERR=0.
- Load 6,9; COMP op=000 held 2 cycles -> two clocks later R0=F, R1=9, ERR=0. Then COMP op=010 -> R0=9 (F&9).
- Load 3,9; COMP op=001 -> R0=A, ERR=1. While in ERROR, LOAD/COMP leave R0=A, R1=9 unchanged.
- Load 3,E; successive COMPs:
  - op=101 -> R0=C
  - op=110 -> R0=8
  - op=111 -> R0=4
  - R1 stays E throughout; ERR=0.
- COMP in EMPTY, and separately COMP in ONE after a single LOAD 5 -> ERR=1 with registers unchanged (R0=0 / R0=5).
- Edge cases:
  - CLR asserted together with COMP/LOAD -> clear wins.
  - reset asserted during EXEC -> R0=0, R1=0, EMPTY, no writeback.
  - With ALP_DEBUG_STATE_EN defined, CS follows 00001 -> 00010 -> 00100 -> 01000 -> 00100 across load, load, compute.
